// File: rtl/booth_mult_r4.sv
// ---------------------------------------------------------------------------
// booth_mult_r4
//   Sequential radix-4 (modified Booth) multiplier. It retires two multiplier
//   bits per cycle, so one multiply takes WIDTH/2+1 iterations plus one DONE
//   cycle. Operands are sign-extended (signed_mode=1) or zero-extended
//   (signed_mode=0) by two bits. This keeps unsigned full-range products and
//   the signed -2^(W-1) * -2^(W-1) corner exact.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, accepted only when not busy (IDLE or DONE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned (captured)
//   mc           multiplicand (captured with start)
//   mp           multiplier   (captured with start)
//   prod         2*WIDTH product, valid with done, held until next done
//   busy         high while iterating
//   done         one-cycle pulse when prod is valid
// ---------------------------------------------------------------------------
module booth_mult_r4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done
);

    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [E-1:0]  a_q, a_d;
    logic signed [E-1:0]  m_q, m_d;
    logic [E-1:0]         q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [2:0]           trip;
    logic [1:0]           mag;
    logic                 neg;
    logic signed [E:0]    a_ext, m_ext, m2_ext, sel, addend, sum;
    logic [2*E-1:0]       aq_next;

    // Two-bit extension. signed_mode only influences the result through
    // this extension, so it does not need its own register.
    function automatic logic [E-1:0] extend(input logic [WIDTH-1:0] v,
                                            input logic sm);
        return {{2{sm & v[WIDTH-1]}}, v};
    endfunction

    // Booth digit magnitude for triplet {Q1,Q0,Q-1}: 0, 1 (M) or 2 (2M).
    function automatic logic [1:0] booth_mag(input logic [2:0] t);
        case (t)
            3'b001, 3'b010, 3'b101, 3'b110: return 2'd1;
            3'b011, 3'b100:                 return 2'd2;
            default:                        return 2'd0;
        endcase
    endfunction

    // Digit is negative for 100, 101 and 110 (111 is a zero digit).
    function automatic logic booth_neg(input logic [2:0] t);
        return t[2] & ~(t[1] & t[0]);
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        trip   = {q_q[1:0], qm1_q};
        mag    = booth_mag(trip);
        neg    = booth_neg(trip);

        // One extra bit so that adding 2M can never overflow.
        a_ext  = {a_q[E-1], a_q};
        m_ext  = {m_q[E-1], m_q};
        m2_ext = m_ext <<< 1;
        case (mag)
            2'd1:    sel = m_ext;
            2'd2:    sel = m2_ext;
            default: sel = '0;
        endcase
        // Subtraction shares the adder: invert and inject carry-in 1.
        addend = neg ? ~sel : sel;
        sum    = a_ext + addend + {{E{1'b0}}, neg};

        // {A,Q} after the arithmetic shift right by two. The sum's sign bit
        // refills A from the top, and its low two bits move into Q.
        aq_next = {sum[E], sum[E:2], sum[1:0], q_q[E-1:2]};

        case (state_q)
            CALC: begin
                a_d   = aq_next[2*E-1:E];
                q_d   = aq_next[E-1:0];
                qm1_d = q_q[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    // Load the product on entry to DONE so it is valid
                    // while done is high.
                    prod_d  = aq_next[2*WIDTH-1:0];
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = IDLE;
                if (start) begin
                    state_d = CALC;
                    a_d     = '0;
                    m_d     = extend(mc, signed_mode);
                    q_d     = extend(mp, signed_mode);
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign prod = prod_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult_r4.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_r4
//   Bench for booth_mult_r4 at WIDTH=8 and WIDTH=16. Expected products come
//   from plain 64-bit integer multiplication of the extended operands.
// ---------------------------------------------------------------------------
module tb_booth_mult_r4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] prod8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] mc16, mp16;
    logic [31:0] prod16;

    int n_cmp = 0;
    int n_bad = 0;

    booth_mult_r4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .mc(mc8), .mp(mp8), .prod(prod8), .busy(busy8), .done(done8)
    );

    booth_mult_r4 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .mc(mc16), .mp(mp16), .prod(prod16), .busy(busy16), .done(done16)
    );

    function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [31:0] model16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 9))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            3: return 8'h00;
            default: return 8'($urandom());
        endcase
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 9))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom());
        endcase
    endfunction

    // Issue one request and wait for done. lat is the cycle index of done
    // counted from the capture edge (1 = cycle right after it), 0 on timeout.
    // Inputs are scrambled right after capture.
    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat, output int bcnt);
        lat = 0; bcnt = 0; p = 'x;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; mc8 = a; mp8 = b;
        @(negedge clk);
        start8 = 1'b0; sm8 = ~sm; mc8 = 8'($urandom()); mp8 = 8'($urandom());
        for (int c = 1; c <= 40; c++) begin
            if (done8) begin
                lat = c; p = prod8;
                break;
            end
            if (busy8) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat, output int bcnt);
        lat = 0; bcnt = 0; p = 'x;
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; mc16 = a; mp16 = b;
        @(negedge clk);
        start16 = 1'b0; sm16 = ~sm; mc16 = 16'($urandom()); mp16 = 16'($urandom());
        for (int c = 1; c <= 40; c++) begin
            if (done16) begin
                lat = c; p = prod16;
                break;
            end
            if (busy16) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; sm8 = 0; mc8 = 0; mp8 = 0;
        start16 = 0; sm16 = 0; mc16 = 0; mp16 = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({prod8, busy8, done8} !== 18'd0) begin
            n_bad++; $display("FAIL reset8: got prod=%h busy=%b done=%b, want all zero", prod8, busy8, done8);
        end
        n_cmp++;
        if ({prod16, busy16, done16} !== 34'd0) begin
            n_bad++; $display("FAIL reset16: got prod=%h busy=%b done=%b, want all zero", prod16, busy16, done16);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [15:0] p; int lat, bc;
        run8(1'b1, 8'h07, 8'hFD, p, lat, bc);
        n_cmp++;
        if (p !== 16'hFFEB) begin n_bad++; $display("FAIL lat_prod: got %h want FFEB", p); end
        n_cmp++;
        if (lat !== 6) begin n_bad++; $display("FAIL lat_cycles: got %0d want 6", lat); end
        n_cmp++;
        if (bc !== 5) begin n_bad++; $display("FAIL lat_busy: got %0d busy cycles want 5", bc); end
        @(negedge clk);
        n_cmp++;
        if (done8 !== 1'b0) begin n_bad++; $display("FAIL done_pulse: done still %b one cycle later, want 0", done8); end
    endtask

    task automatic test_corners8();
        logic [15:0] p; int lat, bc;
        run8(1'b1, 8'h80, 8'h80, p, lat, bc);
        n_cmp++;
        if (p !== 16'h4000) begin n_bad++; $display("FAIL min_sq_s8: got %h want 4000", p); end
        run8(1'b0, 8'hFF, 8'hFF, p, lat, bc);
        n_cmp++;
        if (p !== 16'hFE01) begin n_bad++; $display("FAIL max_sq_u8: got %h want FE01", p); end
        // Prod must hold through IDLE.
        repeat (3) @(negedge clk);
        n_cmp++;
        if (prod8 !== 16'hFE01) begin n_bad++; $display("FAIL prod_hold: got %h want FE01", prod8); end
    endtask

    task automatic test_corners16();
        logic [31:0] p; int lat, bc;
        run16(1'b1, 16'h8000, 16'h7FFF, p, lat, bc);
        n_cmp++;
        if (p !== 32'hC0008000) begin n_bad++; $display("FAIL s16: got %h want C0008000", p); end
        n_cmp++;
        if (lat !== 10) begin n_bad++; $display("FAIL lat16: got %0d want 10", lat); end
        run16(1'b0, 16'h8000, 16'h7FFF, p, lat, bc);
        n_cmp++;
        if (p !== 32'h3FFF8000) begin n_bad++; $display("FAIL u16: got %h want 3FFF8000", p); end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        logic [15:0] last = '0;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'h05; mp8 = 8'h03;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; mc8 = 8'h7F; mp8 = 8'h7F;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done8) begin dones++; last = prod8; end
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 1) begin n_bad++; $display("FAIL busy_start_dones: got %0d pulses want 1", dones); end
        n_cmp++;
        if (last !== 16'h000F) begin n_bad++; $display("FAIL busy_start_prod: got %h want 000F", last); end
        n_cmp++;
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle: busy=%b want 0", busy8); end
    endtask

    task automatic test_abort();
        int dones = 0;
        logic [15:0] p; int lat, bc;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'h12; mp8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({prod8, busy8, done8} !== 18'd0) begin
            n_bad++; $display("FAIL abort8: got prod=%h busy=%b done=%b, want all zero", prod8, busy8, done8);
        end
        n_cmp++;
        if (prod16 !== 32'd0) begin n_bad++; $display("FAIL abort16: got prod=%h want 0", prod16); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        run8(1'b0, 8'h12, 8'h34, p, lat, bc);
        n_cmp++;
        if (p !== 16'h03A8) begin n_bad++; $display("FAIL after_abort: got %h want 03A8", p); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; int lat, bc;
        int lat2 = 0;
        logic [15:0] p2 = 'x;
        run8(1'b1, 8'h05, 8'h07, p, lat, bc);
        n_cmp++;
        if (p !== 16'h0023) begin n_bad++; $display("FAIL b2b_first: got %h want 0023", p); end
        // Still in the DONE cycle: request the next multiply now.
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'hFE; mp8 = 8'h02;
        @(negedge clk);
        start8 = 1'b0; mc8 = 8'h55; mp8 = 8'hAA;
        n_cmp++;
        if (busy8 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: busy=%b want 1", busy8); end
        n_cmp++;
        if (prod8 !== 16'h0023) begin n_bad++; $display("FAIL b2b_retain: got %h want 0023", prod8); end
        for (int c = 1; c <= 40; c++) begin
            if (done8) begin lat2 = c; p2 = prod8; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (p2 !== 16'hFFFC) begin n_bad++; $display("FAIL b2b_second: got %h want FFFC", p2); end
        n_cmp++;
        if (lat2 !== 6) begin n_bad++; $display("FAIL b2b_lat: got %0d want 6", lat2); end
    endtask

    task automatic test_sweep8();
        logic [15:0] p, exp; logic [7:0] a, b; logic sm; int lat, bc;
        for (int i = 0; i < 4000; i++) begin
            a = pick8(); b = pick8(); sm = 1'($urandom());
            exp = model8(sm, a, b);
            run8(sm, a, b, p, lat, bc);
            n_cmp++;
            if (p !== exp || lat !== 6) begin
                n_bad++;
                $display("FAIL sweep8: sm=%b %h*%h got %h lat %0d want %h lat 6", sm, a, b, p, lat, exp);
            end
        end
    endtask

    task automatic test_sweep16();
        logic [31:0] p, exp; logic [15:0] a, b; logic sm; int lat, bc;
        for (int i = 0; i < 3000; i++) begin
            a = pick16(); b = pick16(); sm = 1'($urandom());
            exp = model16(sm, a, b);
            run16(sm, a, b, p, lat, bc);
            n_cmp++;
            if (p !== exp || lat !== 10) begin
                n_bad++;
                $display("FAIL sweep16: sm=%b %h*%h got %h lat %0d want %h lat 10", sm, a, b, p, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners8();
        test_corners16();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        test_sweep8();
        test_sweep16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
